// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with input sync, clock glitch filter and frame timeout.
// Define PS2_BREAK_DECODE_EN to absorb F0/E0 prefixes and report them on key_release/key_ext.
module ps2_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT     = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       KEYSIG_CLK,
  input  logic       KEYSIG_DATA,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err,
`ifdef PS2_BREAK_DECODE_EN
  output logic       key_release,
  output logic       key_ext,
`endif
  output logic       busy
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;
  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic [FW-1:0] r_flt_cnt;
  logic          r_flt, r_flt_d;
  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tmo;
  logic          w_sclk, w_dat, w_edge, w_byte_ok, w_prefix;
  assign w_sclk    = r_clk_sync[SYNC_STAGES-1];
  assign w_dat     = r_dat_sync[SYNC_STAGES-1];
  assign w_edge    = r_flt_d & ~r_flt;
  assign w_byte_ok = w_edge && r_state == S_STOP && w_dat && ^{r_shift, r_par};
  assign busy      = r_state != S_IDLE;
`ifdef PS2_BREAK_DECODE_EN
  assign w_prefix  = r_shift == 8'hF0 || r_shift == 8'hE0;
`else
  assign w_prefix  = 1'b0;
`endif
  // Lines idle high, so presetting to 1 keeps reset release from looking like an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_flt      <= 1'b1;
      r_flt_d    <= 1'b1;
      r_flt_cnt  <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], KEYSIG_CLK};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], KEYSIG_DATA};
      r_flt_d    <= r_flt;
      if (w_sclk == r_flt)
        r_flt_cnt <= '0;
      else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
        r_flt     <= w_sclk;
        r_flt_cnt <= '0;
      end else
        r_flt_cnt <= r_flt_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tmo      <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (w_edge) begin
        r_tmo <= '0;
        case (r_state)
          S_IDLE: begin
            r_bit_cnt <= '0;
            if (w_dat) frame_err <= 1'b1;
            else r_state <= S_DATA;
          end
          S_DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= w_dat;
            r_state <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if (!w_dat) frame_err <= 1'b1;
            else if (!w_byte_ok) parity_err <= 1'b1;
            else if (!w_prefix) begin
              code       <= r_shift;
              code_valid <= 1'b1;
            end
          end
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_tmo == TW'(TIMEOUT - 1)) begin
          r_state   <= S_IDLE;
          r_bit_cnt <= '0;
          r_tmo     <= '0;
          frame_err <= 1'b1;
        end else
          r_tmo <= r_tmo + 1'b1;
      end
    end
  end
`ifdef PS2_BREAK_DECODE_EN
  logic r_rel, r_ext;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rel       <= 1'b0;
      r_ext       <= 1'b0;
      key_release <= 1'b0;
      key_ext     <= 1'b0;
    end else if (w_byte_ok) begin
      if (w_prefix) begin
        r_rel <= r_rel | (r_shift == 8'hF0);
        r_ext <= r_ext | (r_shift == 8'hE0);
      end else begin
        key_release <= r_rel;
        key_ext     <= r_ext;
        r_rel       <= 1'b0;
        r_ext       <= 1'b0;
      end
    end else if (parity_err | frame_err) begin
      r_rel <= 1'b0;
      r_ext <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: scoreboard bench for ps2_rx; expected pulses are queued as frames are driven.
module tb_ps2_rx;
  localparam int SS = 2;
  localparam int FL = 8;
  localparam int TO = 300;
  localparam int H  = 40;
  localparam int LAT = SS + FL + 1;
  localparam logic [2:0] K_OK = 3'b100, K_PAR = 3'b010, K_FRM = 3'b001;
  typedef struct {
    logic [2:0] kind;
    logic [7:0] code;
    logic       rel;
    logic       ext;
    int         lat;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, ps_clk = 1'b1, ps_dat = 1'b1;
  logic [7:0] code;
  logic code_valid, parity_err, frame_err, busy;
`ifdef PS2_BREAK_DECODE_EN
  logic key_release, key_ext;
`endif
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0, t_fall = 0;
  logic [7:0] exp_code = 8'h00;
  logic m_rel = 1'b0, m_ext = 1'b0;
  ps2_rx #(.SYNC_STAGES(SS), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .KEYSIG_CLK(ps_clk), .KEYSIG_DATA(ps_dat),
    .code(code), .code_valid(code_valid), .parity_err(parity_err), .frame_err(frame_err),
`ifdef PS2_BREAK_DECODE_EN
    .key_release(key_release), .key_ext(key_ext),
`endif
    .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && (code_valid | parity_err | frame_err)) begin
      if (q.size() == 0)
        chk("spurious", {29'b0, code_valid, parity_err, frame_err}, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("kind", {29'b0, code_valid, parity_err, frame_err}, {29'b0, e.kind});
        chk("code", {24'b0, code}, {24'b0, e.code});
        chk("latency", cyc - t_fall, e.lat);
`ifdef PS2_BREAK_DECODE_EN
        if (code_valid) chk("flags", {30'b0, key_release, key_ext}, {30'b0, e.rel, e.ext});
`endif
      end
    end
  end
  task automatic exp_byte(input logic [7:0] b);
    exp_t e;
`ifdef PS2_BREAK_DECODE_EN
    if (b == 8'hF0) begin m_rel = 1'b1; return; end
    if (b == 8'hE0) begin m_ext = 1'b1; return; end
`endif
    exp_code = b;
    e = '{K_OK, b, m_rel, m_ext, LAT};
    q.push_back(e);
    m_rel = 1'b0;
    m_ext = 1'b0;
  endtask
  task automatic exp_err(input logic [2:0] kind, input int lat);
    exp_t e;
    e = '{kind, exp_code, 1'b0, 1'b0, lat};
    q.push_back(e);
    m_rel = 1'b0;
    m_ext = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps_dat = f[i];
      repeat (H / 2) @(negedge clk);
      ps_clk = 1'b0;
      t_fall = cyc;
      repeat (H) @(negedge clk);
      ps_clk = 1'b1;
      repeat (H / 2) @(negedge clk);
    end
    ps_dat = 1'b1;
    repeat (H) @(negedge clk);
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask
  task automatic byte_ok(input logic [7:0] b);
    exp_byte(b);
    send(b, 1'b0, 1'b0, 11);
    drain(100);
  endtask
  initial begin
    repeat (4) @(negedge clk);
    chk("rst_code", {24'b0, code}, 0);
    chk("rst_pulses", {29'b0, code_valid, parity_err, frame_err}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 0);
    byte_ok(8'h1C);
    chk("busy_after_1c", {31'b0, busy}, 0);
    exp_err(K_PAR, LAT);
    send(8'h1C, 1'b1, 1'b0, 11);
    drain(100);
    exp_err(K_FRM, LAT);
    send(8'h33, 1'b0, 1'b1, 11);
    drain(100);
    repeat (1000) @(negedge clk);
    byte_ok(8'h5A);
    exp_err(K_FRM, LAT + TO);
    send(8'h29, 1'b0, 1'b0, 5);
    drain(TO + 100);
    chk("busy_after_timeout", {31'b0, busy}, 0);
    byte_ok(8'h29);
    ps_dat = 1'b0;
    ps_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps_clk = 1'b1;
    repeat (50) @(negedge clk);
    ps_dat = 1'b1;
    chk("glitch_busy", {31'b0, busy}, 0);
    send(8'h55, 1'b0, 1'b0, 5);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_code", {24'b0, code}, 0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    exp_code = 8'h00;
    m_rel = 1'b0;
    m_ext = 1'b0;
    repeat (TO + 50) @(negedge clk);
    chk("midrst_idle", {31'b0, busy}, 0);
    for (int i = 0; i < 4; i++) byte_ok(8'($urandom_range(0, 255)));
    byte_ok(8'hE0);
    byte_ok(8'hF0);
    byte_ok(8'h75);
    byte_ok(8'h75);
    exp_err(K_FRM, LAT);
    send(8'h6B, 1'b0, 1'b1, 11);
    drain(100);
    chk("final_code", {24'b0, code}, {24'b0, exp_code});
    chk("final_busy", {31'b0, busy}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
